// File: rtl/interval_meter.sv
// interval_meter: measures the cycles between a start and a stop pulse; 1-cycle result latency; the result is held on valid until ready.
// Optional whole-seconds output (secs) is built only when INTERVAL_METER_SECONDS_EN is defined.
module interval_meter #(
  parameter logic [31:0] FREQUENCY = 32'd2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        valid,
  input  logic        ready,
  output logic [31:0] cycles,
  output logic        overflow
`ifdef INTERVAL_METER_SECONDS_EN
  ,
  output logic [31:0] secs
`endif
);

  localparam logic [31:0] MAX_CNT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_flag;
  logic        r_busy;
  logic        r_valid;
  logic [31:0] r_cycles;
  logic        r_overflow;

  assign busy     = r_busy;
  assign valid    = r_valid;
  assign cycles   = r_cycles;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (!res) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_flag     <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_cycles   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // start has priority over a simultaneous stop
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= 32'd1;
            r_flag  <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state    <= S_HOLD;
            r_busy     <= 1'b0;
            r_valid    <= 1'b1;
            r_cycles   <= r_cnt;
            r_overflow <= r_flag;
          end else if (r_cnt != MAX_CNT) begin
            r_cnt <= r_cnt + 32'd1;
            if (r_cnt == MAX_CNT - 32'd1) begin
              r_flag <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (ready) begin
            r_valid <= 1'b0;
            if (start) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= 32'd1;
              r_flag  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef INTERVAL_METER_SECONDS_EN
  // Invariant while running: r_cnt - 1 == r_sec * FREQUENCY + r_presc.
  logic [31:0] r_presc;
  logic [31:0] r_sec;
  logic [31:0] r_secs;
  logic        w_launch;
  logic        w_advance;
  logic        w_capture;
  logic        w_wrap;
  logic [31:0] w_sec_inc;
  logic [31:0] w_secs_stop;

  assign w_launch    = start && ((r_state == S_IDLE) || ((r_state == S_HOLD) && ready));
  assign w_advance   = (r_state == S_RUN) && !stop && (r_cnt != MAX_CNT);
  assign w_capture   = (r_state == S_RUN) && stop;
  assign w_wrap      = (r_presc == FREQUENCY - 32'd1);
  assign w_sec_inc   = (r_sec == MAX_CNT) ? MAX_CNT : r_sec + 32'd1;
  assign w_secs_stop = w_wrap ? w_sec_inc : r_sec;
  assign secs        = r_secs;

  always_ff @(posedge clk) begin
    if (!res) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_secs  <= '0;
    end else if (w_launch) begin
      r_presc <= '0;
      r_sec   <= '0;
    end else if (w_capture) begin
      r_secs <= w_secs_stop;
    end else if (w_advance) begin
      if (w_wrap) begin
        r_presc <= '0;
        r_sec   <= w_sec_inc;
      end else begin
        r_presc <= r_presc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter: directed scenarios plus random start/stop/ready traffic against a timestamp-based model.
module tb_interval_meter;

  localparam logic [31:0] FREQ = 32'd2;
  localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ready = 1'b0;
  logic        busy;
  logic        valid;
  logic        overflow;
  logic [31:0] cycles;
`ifdef INTERVAL_METER_SECONDS_EN
  logic [31:0] secs;
`endif

  interval_meter #(.FREQUENCY(FREQ)) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .valid    (valid),
    .ready    (ready),
    .cycles   (cycles),
    .overflow (overflow)
`ifdef INTERVAL_METER_SECONDS_EN
    ,
    .secs     (secs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cyc;
    logic        ovf;
    logic [31:0] sec;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_HOLD} mph_t;

  exp_t   q[$];
  mph_t   m_ph = M_IDLE;
  longint m_edge = 0;
  longint m_t0 = 0;
  bit     m_rst = 1'b0;
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  // Reference: a measurement is just the distance between the start edge and the stop edge.
  always @(posedge clk) begin
    longint diff;
    exp_t   e;
    m_edge++;
    m_rst = !res;
    if (!res) begin
      m_ph = M_IDLE;
      q.delete();
    end else begin
      case (m_ph)
        M_IDLE: if (start) begin m_ph = M_RUN; m_t0 = m_edge; end
        M_RUN: if (stop) begin
          diff  = m_edge - m_t0;
          e.cyc = (diff >= longint'(MAXV)) ? MAXV : diff[31:0];
          e.ovf = (diff >= longint'(MAXV));
          e.sec = e.cyc / FREQ;
          q.push_back(e);
          m_ph = M_HOLD;
        end
        M_HOLD: if (ready) begin
          if (start) begin m_ph = M_RUN; m_t0 = m_edge; end
          else m_ph = M_IDLE;
        end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Monitor: compares outputs against the model and pops the scoreboard on handshake.
  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_ph == M_RUN});
    check("valid", {31'd0, valid}, {31'd0, m_ph == M_HOLD});
    if (m_rst) begin
      check("rst_cycles", cycles, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
    end
    if (valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got cycles %h expected no result (edge %0d)", cycles, m_edge);
      end else begin
        check("cycles", cycles, q[0].cyc);
        check("overflow", {31'd0, overflow}, {31'd0, q[0].ovf});
`ifdef INTERVAL_METER_SECONDS_EN
        check("secs", secs, q[0].sec);
`endif
        if (ready && res) void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic p, input logic rd);
    res   = r;
    start = s;
    stop  = p;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held with start asserted
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 1);

    // basic: stop ten edges after start
    step(1, 1, 0, 1);
    repeat (9) step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    repeat (3) step(1, 0, 0, 1);

    // start and stop together, then stop on the next edge
    step(1, 1, 1, 1);
    step(1, 0, 1, 1);
    repeat (3) step(1, 0, 0, 1);

    // start held during the run does not restart
    step(1, 1, 0, 1);
    repeat (4) step(1, 1, 0, 1);
    step(1, 0, 1, 1);
    repeat (2) step(1, 0, 0, 1);

    // backpressure with start/stop noise, then back-to-back launch
    step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (20) step(1, 1'($urandom % 2), 1'($urandom % 2), 0);
    step(1, 1, 0, 1);
    repeat (7) step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    repeat (3) step(1, 0, 0, 1);

    // saturation via deposit into the running counter
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    dut.r_cnt = 32'hFFFF_FFFE;
`ifdef INTERVAL_METER_SECONDS_EN
    dut.r_sec   = 32'hFFFF_FFFD / FREQ;
    dut.r_presc = 32'hFFFF_FFFD % FREQ;
`endif
    m_t0 = m_edge + 1 - longint'(32'hFFFF_FFFE);
    repeat (4) step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    repeat (3) step(1, 0, 0, 1);

    // reset mid-run
    step(1, 1, 0, 1);
    repeat (3) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (2) step(1, 0, 0, 1);

    // reset mid-hold discards the pending result
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (2) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1);

    // random traffic
    repeat (3000) begin
      step(1'(($urandom % 200) != 0), 1'(($urandom % 8) == 0),
           1'(($urandom % 6) == 0), 1'(($urandom % 3) != 0));
    end

    // drain any run still in flight
    step(1, 0, 1, 1);
    repeat (4) step(1, 0, 0, 1);
    check("drain_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
